// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding and the default half-period divider.
// The slave-side bench imports the same package.
package spi_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 4;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_HIGH  = 3'd2;
    localparam spi_state_t ST_LOW   = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: o_tick pulses on the last of every CLK_DIV enabled cycles.
// The count restarts from zero whenever i_en drops and after every tick.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned     CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tick = i_en && (cnt_q == CNT_LAST);

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-only master: one holding byte ahead of an 8-bit shifter, MSB first.
// Every pin comes straight from a flop; back-to-back bytes keep CS low with no clock gap.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_w_en,
    output logic       o_rdy,
    output logic       o_busy,
    output logic       o_CLK,
    output logic       o_MOSI,
    output logic       o_CS_n
);

    spi_state_t state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       rdy_q, rdy_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       busy_q, busy_d;
    logic       div_en;
    logic       tick;

    assign div_en = (state_q != ST_IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (div_en),
        .o_tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rdy_d     = rdy_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;

        // Accept and drain are exclusive: accept needs rdy_q=1, drain needs rdy_q=0.
        if (i_w_en && rdy_q) begin
            hold_d = i_data;
            rdy_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rdy_q) begin
                    shift_d   = hold_q;
                    rdy_d     = 1'b1;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q != 3'd7) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        state_d = ST_LOW;
                    end else if (!rdy_q) begin
                        shift_d = hold_q;
                        rdy_d   = 1'b1;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = ~cs_n_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            rdy_q     <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rdy_q     <= rdy_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
        end
    end

    assign o_rdy  = rdy_q;
    assign o_busy = busy_q;
    assign o_CLK  = sclk_q;
    assign o_MOSI = shift_q[7];
    assign o_CS_n = cs_n_q;

endmodule
